// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, drives the instruction ROM port and fills IF/ID.
// Optional MIPS branch delay slot handling is enabled with `define IF_DELAY_SLOT_EN.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ce,
  output logic [31:0] addr,
  input  logic [31:0] data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc, pc_n, target;
  logic [XLEN-1:0] if_pc_n, if_inst_n;
  logic            if_valid_n;
  logic            accept, update;
  logic            unused_low_bits;

  assign addr            = pc;
  assign target          = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_low_bits = ^redirect_pc[1:0];

`ifdef IF_DELAY_SLOT_EN
  logic            pend, pend_n;
  logic [XLEN-1:0] pend_pc, pend_pc_n;

  // Delay slot word is always kept; a stalled redirect is parked until stall drops.
  always_comb begin
    pc_n      = pc;
    pend_n    = pend;
    pend_pc_n = pend_pc;
    accept    = 1'b0;
    update    = !stall;
    if (redirect && !stall) begin
      accept = ce;
      pc_n   = target;
      pend_n = 1'b0;
    end else if (redirect) begin
      pend_n    = 1'b1;
      pend_pc_n = target;
    end else if (pend && !stall) begin
      accept = ce;
      pc_n   = pend_pc;
      pend_n = 1'b0;
    end else if (!stall) begin
      accept = ce;
      if (ce) pc_n = pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend    <= 1'b0;
      pend_pc <= '0;
    end else begin
      pend    <= pend_n;
      pend_pc <= pend_pc_n;
    end
  end
`else
  // Redirect squashes the wrong-path word presented this cycle, even under stall.
  always_comb begin
    pc_n   = pc;
    accept = 1'b0;
    update = redirect || !stall;
    if (redirect) begin
      pc_n = target;
    end else if (!stall) begin
      accept = ce;
      if (ce) pc_n = pc + XLEN'(4);
    end
  end
`endif

  always_comb begin
    if_pc_n    = if_pc;
    if_inst_n  = if_inst;
    if_valid_n = if_valid;
    if (update) if_valid_n = accept;
    if (accept) begin
      if_pc_n   = pc;
      if_inst_n = data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      ce       <= 1'b0;
      if_pc    <= '0;
      if_inst  <= '0;
      if_valid <= 1'b0;
    end else begin
      pc       <= pc_n;
      ce       <= 1'b1;
      if_pc    <= if_pc_n;
      if_inst  <= if_inst_n;
      if_valid <= if_valid_n;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed test-plan sequence plus random stall/redirect/reset traffic,
// every cycle compared against a transaction-level model of the fetch stream.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc, data, addr, if_pc, if_inst;
  logic        ce, if_valid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .data(data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h012a4020;
    if (a == 32'h4) return 32'h02328020;
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  assign data = mem_word(addr);

  // Model: where the fetcher is, whether it has started, what IF/ID holds, any parked target.
  logic [31:0] m_pc, m_if_pc, m_if_inst, m_pend_pc;
  logic        m_started, m_if_valid, m_pend;

  task automatic model_step(input logic r, s, rd, input logic [31:0] rpc);
    logic [31:0] tgt;
    logic        take, hold;
    tgt = {rpc[31:2], 2'b00};
    if (r) begin
      m_pc = 32'h0; m_started = 0; m_if_pc = 0; m_if_inst = 0; m_if_valid = 0;
      m_pend = 0; m_pend_pc = 0;
      return;
    end
    take = 0;
    hold = s;
`ifdef IF_DELAY_SLOT_EN
    if (!s) take = m_started;
    if (rd && s) begin
      m_pend = 1; m_pend_pc = tgt;
    end
    if (take) begin
      m_if_pc = m_pc; m_if_inst = mem_word(m_pc);
    end
    if (!s) begin
      if (rd) m_pc = tgt;
      else if (m_pend) m_pc = m_pend_pc;
      else if (take) m_pc = m_pc + 4;
      m_pend = 0;
    end
`else
    if (rd) begin
      m_pc = tgt; hold = 0;
    end else if (!s) begin
      take = m_started;
      if (take) begin
        m_if_pc = m_pc; m_if_inst = mem_word(m_pc); m_pc = m_pc + 4;
      end
    end
`endif
    if (!hold) m_if_valid = take;
    m_started = 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("ce", 32'(ce), 32'(m_started));
    chk("addr", addr, m_pc);
    chk("if_valid", 32'(if_valid), 32'(m_if_valid));
    chk("if_pc", if_pc, m_if_pc);
    chk("if_inst", if_inst, m_if_inst);
  endtask

  task automatic cycle(input logic r, s, rd, input logic [31:0] rpc);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    model_step(r, s, rd, rpc);
    #1;
    compare_all();
  endtask

  task automatic run_to(input logic [31:0] target);
    for (int i = 0; i < 64 && addr !== target; i++) cycle(0, 0, 0, 32'h0);
    chk("run_to_addr", addr, target);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ce"}, 32'(ce), 32'h0);
    chk({tag, "_addr"}, addr, 32'h0);
    chk({tag, "_if_valid"}, 32'(if_valid), 32'h0);
    chk({tag, "_if_pc"}, if_pc, 32'h0);
    chk({tag, "_if_inst"}, if_inst, 32'h0);
  endtask

  initial begin
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
    model_step(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk_reset_values("reset");

    // Reset release: one bubble, then back-to-back fetches
    cycle(0, 0, 0, 0);
    chk("bubble_ce", 32'(ce), 32'h1);
    chk("bubble_addr", addr, 32'h0);
    cycle(0, 0, 0, 0);
    chk("first_if_pc", if_pc, 32'h0);
    chk("first_if_inst", if_inst, 32'h012a4020);
    chk("first_if_valid", 32'(if_valid), 32'h1);
    cycle(0, 0, 0, 0);
    chk("second_if_pc", if_pc, 32'h4);
    chk("second_if_inst", if_inst, 32'h02328020);

    // Stall hold at addr 8
    chk("stall_start_addr", addr, 32'h8);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0);
      chk("stall_addr", addr, 32'h8);
      chk("stall_if_pc", if_pc, 32'h4);
      chk("stall_if_inst", if_inst, 32'h02328020);
    end
    cycle(0, 0, 0, 0);
    chk("unstall_if_pc", if_pc, 32'h8);

    // Redirect at 0x20 to 0x13 (low bits dropped)
    run_to(32'h20);
    cycle(0, 0, 1, 32'h0000_0013);
    chk("redir_addr", addr, 32'h10);
`ifdef IF_DELAY_SLOT_EN
    chk("redir_slot_pc", if_pc, 32'h20);
    chk("redir_slot_valid", 32'(if_valid), 32'h1);
`else
    chk("redir_flush_valid", 32'(if_valid), 32'h0);
`endif
    cycle(0, 0, 0, 0);
    chk("redir_target_if_pc", if_pc, 32'h10);

    // Redirect during stall at 0x24
    run_to(32'h24);
    cycle(0, 1, 1, 32'h40);
`ifdef IF_DELAY_SLOT_EN
    chk("pend_addr0", addr, 32'h24);
    cycle(0, 1, 0, 0);
    chk("pend_addr1", addr, 32'h24);
    cycle(0, 1, 0, 0);
    chk("pend_addr2", addr, 32'h24);
    cycle(0, 0, 0, 0);
    chk("pend_release_if_pc", if_pc, 32'h24);
    chk("pend_release_addr", addr, 32'h40);
`else
    chk("stall_redir_addr", addr, 32'h40);
    chk("stall_redir_valid", 32'(if_valid), 32'h0);
`endif
    cycle(0, 0, 0, 0);
    chk("after_redir_if_pc", if_pc, 32'h40);

    // PC wrap
    cycle(0, 0, 1, 32'hFFFF_FFFF);
    chk("wrap_addr_top", addr, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0);
    chk("wrap_addr_zero", addr, 32'h0);
    chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);

    // Reset in the middle of a stall with a redirect outstanding
    cycle(0, 1, 1, 32'h100);
    cycle(1, 1, 0, 0);
    chk_reset_values("mid_reset");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, s, rd;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 199) == 0);
      s   = ($urandom_range(0, 99) < 30);
      rd  = ($urandom_range(0, 99) < 12);
      rpc = ($urandom_range(0, 19) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : $urandom;
      cycle(r, s, rd, rpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit: the initiator side of the instruction-memory read port. It owns the PC, drives the chip-enable and byte address into the instruction ROM, and samples the returned word. Each fetched instruction and its PC are registered into the IF/ID pipeline register. Downstream stages can stall the unit or redirect it on branches and jumps.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be zero.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ce  out  1  instruction memory chip enable; registered.
- addr  out  32  instruction byte address (current PC); registered.
- data  in  32  instruction word from memory; combinational response to ce/addr in the same cycle.
- stall  in  1  ID stage cannot accept; hold PC and IF/ID.
- redirect  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  target byte address; bits [1:0] ignored and forced to 0.
- if_pc  out  32  PC of instruction in IF/ID.
- if_inst  out  32  instruction in IF/ID.
- if_valid  out  1  IF/ID holds a live instruction.

## Operation
- State: pc (32), ce (1), if_pc/if_inst/if_valid. With IF_DELAY_SLOT_EN only: pend (1) and pend_pc (32).
- Fetch is active when ce=1. A fetch is accepted in a cycle when ce=1, stall=0 and no flush applies. On acceptance: if_inst<=data, if_pc<=pc, if_valid<=1, pc<=pc+4.
- When ce=0, pc holds, if_valid<=0, and if_inst/if_pc hold.
- On stall=1 with no redirect, pc, if_pc, if_inst and if_valid all hold.
- Redirect without delay slot: redirect=1 forces pc<={redirect_pc[31:2],2'b00} and if_valid<=0. This flushes the wrong-path word returned this cycle. Redirect overrides stall.
- Redirect with delay slot: see Configuration.
- PC arithmetic is modulo 2^32. 32'hFFFF_FFFC+4 wraps to 32'h0000_0000. No range check against memory size.
- Priority, highest first: rst, redirect, pend release, stall, normal advance.

## Timing
- Reset values: ce=0, addr=RESET_PC, if_pc=0, if_inst=0, if_valid=0, pend=0, pend_pc=0.
- The first edge with rst=0 sets ce=1 and leaves pc=RESET_PC. This gives exactly one bubble cycle after reset.
- Latency: the word at addr A, presented in cycle N, appears on if_inst with if_pc=A in cycle N+1.
- Throughput: one instruction per cycle while stall=0 and redirect=0.
- Redirect asserted in cycle N (no delay slot): addr=target in cycle N+1, and if_valid=0 in cycle N+1.
- Asserting rst mid-stall or mid-pending-redirect discards all state to reset values on that edge.

## Configuration
- Macro: IF_DELAY_SLOT_EN.
- Defined (MIPS branch delay slot):
  - redirect=1 with stall=0: the word fetched this cycle (the delay slot) is accepted normally, and pc<=target.
  - redirect=1 with stall=1: pend<=1 and pend_pc<=target; pc and IF/ID hold.
  - While pend=1 and stall=1: hold.
  - First cycle with pend=1 and stall=0: delay slot is accepted, pc<=pend_pc, pend<=0.
  - A redirect arriving while pend=1 overwrites pend_pc.
- Undefined: pend and pend_pc are absent. The flush behaviour in Operation applies.

## Test plan
- Reset release, stall=0, memory holding 32'h012a4020 at 0 and 32'h02328020 at 4:
  - cycle 1 after release: ce=1, addr=0.
  - next cycle: if_pc=0, if_inst=32'h012a4020, if_valid=1.
  - following cycle: if_pc=4, if_inst=32'h02328020.
- stall=1 for 3 cycles at addr=8: addr stays 8 and if_pc/if_inst are unchanged throughout. After stall drops, if_pc=8 on the next cycle with no instruction lost or duplicated.
- Without macro, redirect=1 with redirect_pc=32'h0000_0013 at addr=0x20: next cycle addr=0x10 and if_valid=0. The following cycle has if_pc=0x10.
- With IF_DELAY_SLOT_EN, same stimulus: next cycle if_pc=0x20, if_valid=1, addr=0x10. The cycle after has if_pc=0x10.
- With IF_DELAY_SLOT_EN, redirect to 0x40 during stall at addr=0x24, stall held 2 more cycles: addr stays 0x24. On stall release, if_pc=0x24 first, then addr=0x40.
- Wrap: force pc to 32'hFFFF_FFFC via redirect. Next accepted fetch gives addr=32'h0000_0000. rst asserted in any cycle restores all reset values on that edge.
